// File: rtl/chain_code_pkg.sv
// Shared definitions for the XNOR-chain word code: decoder state encoding and
// the reference encoder function used by the bench and the future encoder.
package chain_code_pkg;

    // Widest word the shared encode function handles; callers truncate.
    localparam int MAX_WD = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } chain_dec_state_t;

    // enc[0] = dat[0], enc[j] = ~dat[j-1] ^ dat[j]. Bit j depends only on
    // dat[j-1:j], so the low WD bits of the result are the WD-bit code word.
    function automatic logic [MAX_WD-1:0] chain_encode(input logic [MAX_WD-1:0] dat);
        logic [MAX_WD-1:0] enc;
        enc[0] = dat[0];
        for (int j = 1; j < MAX_WD; j++) begin
            enc[j] = ~dat[j-1] ^ dat[j];
        end
        return enc;
    endfunction

endpackage

// File: rtl/chain_decoder_if.sv
// Input/output handshake bundle of the chain decoder.
interface chain_decoder_if #(
    parameter int WD = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [WD-1:0] in_enc;
    logic          out_valid;
    logic          out_ready;
    logic [WD-1:0] out_dat;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, in_enc, out_ready,
        input  in_ready, out_valid, out_dat
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_enc, out_ready,
        output in_ready, out_valid, out_dat
    );
endinterface

// File: rtl/chain_decoder.sv
// Bit-serial XNOR-chain decoder: accepts one encoded word, resolves the carry
// chain one bit per clock, then holds the decoded word until it is taken.
module chain_decoder
    import chain_code_pkg::*;
#(
    parameter int WD   = 4,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RSTX,
    chain_decoder_if.slave  bus,
    output logic            busy,
    output logic [CNTW-1:0] word_cnt
);

    localparam int IW = (WD > 1) ? $clog2(WD) : 1;

    chain_dec_state_t state;
    logic [WD-1:0]    enc_q;
    logic [WD-1:0]    dat_q;
    logic [IW-1:0]    idx;
    logic             prev;
    logic             bit_d;

    // Bit 0 passes straight through; every later bit is enc ^ ~previous bit.
    assign bit_d = enc_q[idx] ^ ((idx != '0) & ~prev);

    // Handshake outputs decode from state only, so no input reaches them combinationally.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_dat   = dat_q;
    assign busy          = (state == BUSY);

    // Control FSM plus the serial decode datapath.
    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            state    <= IDLE;
            enc_q    <= '0;
            dat_q    <= '0;
            idx      <= '0;
            prev     <= 1'b0;
            word_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        enc_q <= bus.in_enc;
                        idx   <= '0;
                        prev  <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    dat_q[idx] <= bit_d;
                    prev       <= bit_d;
                    idx        <= idx + 1'b1;
                    if (idx == IW'(WD - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        word_cnt <= word_cnt + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
